// File: rtl/keyboard_receive.sv
// Key-event receiver: keeps a registered image of every key and queues state
// changes in a FIFO toward a valid/ready consumer, with sticky error flags.
module keyboard_receive #(
  parameter int NKEYS = 103,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             on_event,
  input  logic [7:0]       key_event,
  output logic [NKEYS-1:0] key_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic [CW-1:0]    fifo_count,
  output logic             overflow,
  output logic             bad_code,
  input  logic             status_clear
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [7:0]    NK   = 8'(NKEYS);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic       pressed;
    logic [6:0] code;
  } kev_t;

  kev_t             ev;
  logic [127:0]     state_ext;
  logic [NKEYS-1:0] key_next;
  logic             code_bad, changes, full, pop, push_ok, ovf_set;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [7:0]       head_nxt;
  logic [7:0]       mem [DEPTH];

  assign ev        = kev_t'(key_event);
  // Zero-padded so any 7-bit code can be looked up without a range check.
  assign state_ext = 128'(key_state);

  assign code_bad  = on_event && ({1'b0, ev.code} >= NK);
  assign changes   = on_event && !code_bad && (state_ext[ev.code] != ev.pressed);
  assign full      = (fifo_count == FULL);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot the full FIFO would otherwise lack.
  assign push_ok   = changes && (!full || pop);
  assign ovf_set   = changes && full && !pop;

  always_comb begin
    key_next = key_state;
    for (int k = 0; k < NKEYS; k++)
      if (changes && ev.code == 7'(k)) key_next[k] = ev.pressed;
  end

  always_comb begin
    count_nxt  = fifo_count;
    rd_ptr_nxt = rd_ptr;
    if (pop) rd_ptr_nxt = rd_ptr + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase
    // The incoming entry becomes the head only when it is the sole occupant.
    head_nxt = out_code;
    if (push_ok && count_nxt == CW'(1)) head_nxt = ev;
    else if (count_nxt != '0)           head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_state  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_code   <= '0;
      overflow   <= 1'b0;
      bad_code   <= 1'b0;
    end else begin
      key_state  <= key_next;
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      out_code   <= head_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (ovf_set)           overflow <= 1'b1;
      else if (status_clear) overflow <= 1'b0;
      if (code_bad)          bad_code <= 1'b1;
      else if (status_clear) bad_code <= 1'b0;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clock)
    if (push_ok) mem[wr_ptr] <= ev;

endmodule
